// File: rtl/conv2_xnor_pe.sv
// conv2_xnor_pe: binary-weight conv2 compute stage.
//   Takes one packed 8-channel x 3x3 binary window per valid cycle, computes
//   NUM_FILTERS XNOR-popcount dot products against per-filter weights,
//   thresholds each one to an activation bit and tags the result with its
//   output row/column. frame_done marks the last position of a frame.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   window_in         packed window, bit c*9+k = channel c, tap k
//   valid_in          window_in valid this cycle
//   wt_we/wt_addr     weight/threshold write strobe and filter index
//   wt_data/th_data   filter weights (window packing) and threshold
//   act_out           activation bits, bit f = filter f
//   valid_out         act_out valid (3 cycles after valid_in)
//   row_out/col_out   output position of act_out
//   frame_done        high with the last position of the frame
//   pop_out           (CONV2_POP_OUT_EN only) field f = popcount of filter f
//
// Optional feature macro: CONV2_POP_OUT_EN adds the pop_out port.

// One filter: weight/threshold entry plus its three pipeline stages.
module conv2_xnor_lane #(
    parameter int WIN_BITS = 72,
    parameter int POP_W    = 7,
    parameter int FA_W     = 4,
    parameter int LANE_ID  = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s1_en,
    input  logic                s2_en,
    input  logic                s3_en,
    input  logic [WIN_BITS-1:0] window_in,
    input  logic                wt_we,
    input  logic [FA_W-1:0]     wt_addr,
    input  logic [WIN_BITS-1:0] wt_data,
    input  logic [POP_W-1:0]    th_data,
    output logic                act_q
`ifdef CONV2_POP_OUT_EN
    ,
    output logic [POP_W-1:0]    pop3_q
`endif
);
    localparam logic [FA_W-1:0] MY_ADDR = FA_W'(LANE_ID);

    logic [WIN_BITS-1:0] w_q;
    logic [POP_W-1:0]    th_q;
    logic [WIN_BITS-1:0] xnor_q;
    logic [POP_W-1:0]    th1_q;
    logic [POP_W-1:0]    pop2_q;
    logic [POP_W-1:0]    th2_q;
    logic [POP_W-1:0]    pop_c;

    always_comb begin
        pop_c = '0;
        for (int i = 0; i < WIN_BITS; i++)
            pop_c = pop_c + POP_W'(xnor_q[i]);
    end

    // The S1 capture reads w_q/th_q before this edge's write lands, so a
    // window arriving with a write to the same filter sees the old entry.
    // The threshold travels with the window so later writes cannot skew it.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_q    <= '0;
            th_q   <= '0;
            xnor_q <= '0;
            th1_q  <= '0;
            pop2_q <= '0;
            th2_q  <= '0;
            act_q  <= 1'b0;
        end else begin
            if (wt_we && wt_addr == MY_ADDR) begin
                w_q  <= wt_data;
                th_q <= th_data;
            end
            if (s1_en) begin
                xnor_q <= ~(window_in ^ w_q);
                th1_q  <= th_q;
            end
            if (s2_en) begin
                pop2_q <= pop_c;
                th2_q  <= th1_q;
            end
            if (s3_en)
                act_q <= (pop2_q >= th2_q);
        end
    end

`ifdef CONV2_POP_OUT_EN
    always_ff @(posedge clk) begin
        if (rst)
            pop3_q <= '0;
        else if (s3_en)
            pop3_q <= pop2_q;
    end
`endif
endmodule

module conv2_xnor_pe #(
    parameter int NUM_FILTERS = 16,
    parameter int WIN_BITS    = 72,
    parameter int POP_W       = 7,
    parameter int OUT_W       = 11,
    parameter int OUT_H       = 11,
    parameter int FA_W        = 4,
    parameter int POS_W       = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIN_BITS-1:0]    window_in,
    input  logic                   valid_in,
    input  logic                   wt_we,
    input  logic [FA_W-1:0]        wt_addr,
    input  logic [WIN_BITS-1:0]    wt_data,
    input  logic [POP_W-1:0]       th_data,
    output logic [NUM_FILTERS-1:0] act_out,
    output logic                   valid_out,
    output logic [POS_W-1:0]       row_out,
    output logic [POS_W-1:0]       col_out,
    output logic                   frame_done
`ifdef CONV2_POP_OUT_EN
    ,
    output logic [NUM_FILTERS*POP_W-1:0] pop_out
`endif
);
    localparam int STAGES = 3;
    localparam logic [POS_W-1:0] COL_LAST = POS_W'(OUT_W - 1);
    localparam logic [POS_W-1:0] ROW_LAST = POS_W'(OUT_H - 1);

    // vld_pipe[0] is the incoming valid, vld_pipe[s] the valid of stage s.
    logic [STAGES:0] vld_pipe;
    logic [STAGES:1] vld_q;

    assign vld_pipe  = {vld_q, valid_in};
    assign valid_out = vld_pipe[STAGES];

    always_ff @(posedge clk) begin
        if (rst)
            vld_q <= '0;
        else
            vld_q <= vld_pipe[STAGES-1:0];
    end

    // An out-of-range wt_addr matches no lane, so such writes are dropped.
    for (genvar f = 0; f < NUM_FILTERS; f++) begin : g_lane
        conv2_xnor_lane #(
            .WIN_BITS (WIN_BITS),
            .POP_W    (POP_W),
            .FA_W     (FA_W),
            .LANE_ID  (f)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .s1_en     (vld_pipe[0]),
            .s2_en     (vld_pipe[1]),
            .s3_en     (vld_pipe[2]),
            .window_in (window_in),
            .wt_we     (wt_we),
            .wt_addr   (wt_addr),
            .wt_data   (wt_data),
            .th_data   (th_data),
            .act_q     (act_out[f])
`ifdef CONV2_POP_OUT_EN
            ,
            .pop3_q    (pop_out[f*POP_W +: POP_W])
`endif
        );
    end

    // nxt_row/nxt_col hold the position of the next result; they are copied
    // into row_out/col_out together with act_out so the pair holds during gaps.
    logic [POS_W-1:0] nxt_row, nxt_col;
    logic             at_last;

    assign at_last = (nxt_row == ROW_LAST) && (nxt_col == COL_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            nxt_row    <= '0;
            nxt_col    <= '0;
            row_out    <= '0;
            col_out    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (vld_pipe[2]) begin
                row_out    <= nxt_row;
                col_out    <= nxt_col;
                frame_done <= at_last;
                if (nxt_col == COL_LAST) begin
                    nxt_col <= '0;
                    nxt_row <= (nxt_row == ROW_LAST) ? '0 : nxt_row + 1'b1;
                end else begin
                    nxt_col <= nxt_col + 1'b1;
                end
            end
        end
    end
endmodule
